// File: rtl/garage_door_position_tracker.sv
// Door-side limit-switch emulator: tracks door position from motor commands and travel ticks.
// Optional stall watchdog is enabled by defining STALL_WDG_EN.
module garage_door_position_tracker #(
    parameter int POS_W     = 8,
    parameter int TRAVEL    = 200,
    parameter int STALL_CYC = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             UP_M,
    input  logic             DN_M,
    input  logic             STEP,
    output logic             UP_Max,
    output logic             DN_MAX,
    output logic [POS_W-1:0] POS,
    output logic [1:0]       STATE,
    output logic             FAULT
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_OPENING = 2'b01,
        ST_CLOSING = 2'b10,
        ST_FAULT   = 2'b11
    } state_t;

    localparam logic [POS_W-1:0] TRAVEL_C = POS_W'(TRAVEL);
    localparam logic [POS_W-1:0] ZERO_C   = {POS_W{1'b0}};

    if ((TRAVEL < 2) || (TRAVEL >= (2 ** POS_W)) || (STALL_CYC < 1)) begin : g_bad_param
        $error("garage_door_position_tracker: illegal parameter set");
    end

    state_t           state_r;
    state_t           state_s;
    state_t           dir_s;
    logic [POS_W-1:0] pos_s;
    logic             fault_s;
    logic             stall_hit_s;

`ifdef STALL_WDG_EN
    localparam int CNT_W = $clog2(STALL_CYC + 1);

    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] stall_cnt_s;

    // Stall counter: counts idle drive cycles away from the limit; any tick, release or limit clears it.
    always_comb begin
        stall_cnt_s = {CNT_W{1'b0}};
        if (!FAULT && !STEP &&
            (((dir_s == ST_OPENING) && (POS != TRAVEL_C)) ||
             ((dir_s == ST_CLOSING) && (POS != ZERO_C)))) begin
            stall_cnt_s = stall_cnt_r + CNT_W'(1);
        end else begin
            stall_cnt_s = {CNT_W{1'b0}};
        end
        stall_hit_s = (stall_cnt_s == CNT_W'(STALL_CYC));
    end

    // Stall counter register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_r <= stall_cnt_s;
        end
    end
`else
    assign stall_hit_s = 1'b0;
`endif

    // Next-state decode and position update; the fault path overrides any step on the same edge.
    always_comb begin
        dir_s   = ST_IDLE;
        state_s = ST_IDLE;
        pos_s   = POS;
        if (UP_M && !DN_M) begin
            dir_s = ST_OPENING;
        end else if (DN_M && !UP_M) begin
            dir_s = ST_CLOSING;
        end else begin
            dir_s = ST_IDLE;
        end
        fault_s = FAULT | (UP_M & DN_M) | stall_hit_s;
        if (fault_s) begin
            state_s = ST_FAULT;
        end else begin
            state_s = dir_s;
        end
        case (state_s)
            ST_OPENING: begin
                if (STEP && (POS < TRAVEL_C)) begin
                    pos_s = POS + POS_W'(1);
                end else begin
                    pos_s = POS;
                end
            end
            ST_CLOSING: begin
                if (STEP && (POS != ZERO_C)) begin
                    pos_s = POS - POS_W'(1);
                end else begin
                    pos_s = POS;
                end
            end
            default: pos_s = POS;
        endcase
    end

    // Output registers; limit flags come from the next position so they rise with POS.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            POS     <= ZERO_C;
            UP_Max  <= 1'b0;
            DN_MAX  <= 1'b1;
            state_r <= ST_IDLE;
            FAULT   <= 1'b0;
        end else begin
            POS     <= pos_s;
            UP_Max  <= (pos_s == TRAVEL_C);
            DN_MAX  <= (pos_s == ZERO_C);
            state_r <= state_s;
            FAULT   <= fault_s;
        end
    end

    assign STATE = state_r;

endmodule

// File: tb/tb_garage_door_position_tracker.sv
// Bench for garage_door_position_tracker: directed scenarios plus random traffic against a
// behavioural door model (honours STALL_WDG_EN the same way as the design build).
module tb_garage_door_position_tracker;

    localparam int TRAVEL    = 200;
    localparam int STALL_CYC = 64;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       UP_M = 1'b0;
    logic       DN_M = 1'b0;
    logic       STEP = 1'b0;
    logic       UP_Max;
    logic       DN_MAX;
    logic [7:0] POS;
    logic [1:0] STATE;
    logic       FAULT;

    garage_door_position_tracker dut (
        .CLK    (CLK),
        .RST    (RST),
        .UP_M   (UP_M),
        .DN_M   (DN_M),
        .STEP   (STEP),
        .UP_Max (UP_Max),
        .DN_MAX (DN_MAX),
        .POS    (POS),
        .STATE  (STATE),
        .FAULT  (FAULT)
    );

    always #5 CLK = ~CLK;

    int    checks = 0;
    int    fails  = 0;
    string phase  = "reset";

    // Door model: position in travel units, sticky fault, last decoded state, idle-drive count.
    int m_pos   = 0;
    bit m_fault = 1'b0;
    int m_state = 0;
    int m_idle  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("POS",    {24'd0, POS},    m_pos);
        check("UP_Max", {31'd0, UP_Max}, (m_pos == TRAVEL) ? 32'd1 : 32'd0);
        check("DN_MAX", {31'd0, DN_MAX}, (m_pos == 0) ? 32'd1 : 32'd0);
        check("STATE",  {30'd0, STATE},  m_state);
        check("FAULT",  {31'd0, FAULT},  {31'd0, m_fault});
    endtask

    task automatic model_reset();
        m_pos = 0; m_fault = 1'b0; m_state = 0; m_idle = 0;
    endtask

    task automatic model_edge(input bit up, input bit dn, input bit st);
        int dir;
        dir = (up && !dn) ? 1 : ((dn && !up) ? 2 : 0);
`ifdef STALL_WDG_EN
        if (!m_fault && !st && ((dir == 1 && m_pos != TRAVEL) || (dir == 2 && m_pos != 0)))
            m_idle++;
        else
            m_idle = 0;
        if (m_idle == STALL_CYC) m_fault = 1'b1;
`endif
        if (up && dn) m_fault = 1'b1;
        m_state = m_fault ? 3 : dir;
        if (!m_fault && st) begin
            if (dir == 1 && m_pos < TRAVEL) m_pos++;
            else if (dir == 2 && m_pos > 0) m_pos--;
        end
    endtask

    // One clock: drive, take the edge, update model, compare 1 time unit later, return at negedge.
    task automatic cycle(input bit up, input bit dn, input bit st);
        UP_M = up; DN_M = dn; STEP = st;
        @(posedge CLK);
        model_edge(up, dn, st);
        #1;
        check_all();
        @(negedge CLK);
    endtask

    // Asynchronous reset asserted between edges, checked before the next edge, held over one edge.
    task automatic do_reset();
        UP_M = 1'b0; DN_M = 1'b0; STEP = 1'b0;
        RST = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge CLK);
        #1;
        check_all();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic travel(input bit up, input int steps, input int gap);
        for (int i = 0; i < steps; i++) begin
            cycle(up, !up, 1'b1);
            for (int g = 1; g < gap; g++) cycle(up, !up, 1'b0);
        end
    endtask

    initial begin
        int cmd;
        @(negedge CLK);
        phase = "reset";
        @(posedge CLK); @(posedge CLK); #1;
        check_all();
        @(negedge CLK);
        RST = 1'b0;

        phase = "open";
        travel(1'b1, TRAVEL, 4);

        phase = "saturate";
        travel(1'b1, 5, 4);

        phase = "close";
        travel(1'b0, TRAVEL, 4);

        phase = "fault";
        travel(1'b1, 50, 2);
        cycle(1'b1, 1'b1, 1'b1);
        travel(1'b1, 3, 2);
        cycle(1'b0, 1'b1, 1'b1);

        phase = "reset_mid";
        do_reset();
        travel(1'b1, 120, 2);
        do_reset();

        phase = "stall";
        travel(1'b1, 10, 1);
        for (int i = 0; i < 200; i++) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        do_reset();

        phase = "reversal";
        travel(1'b1, 7, 1);
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);

        phase = "random";
        cmd = 1;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 15) == 0) cmd = $urandom_range(0, 2);
            if ($urandom_range(0, 399) == 0)
                cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)));
            else if (m_fault && $urandom_range(0, 9) == 0)
                do_reset();
            else
                cycle(cmd == 1, cmd == 2, $urandom_range(0, 3) != 0);
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
